// File: rtl/mac_fifo_loader.sv
// mac_fifo_loader: write-side and sequencing controller for the vectored MAC
// FIFO array. Loads an ROWS x COLS A matrix row-major into the per-row A
// FIFOs, then a COLS-entry B vector into the B FIFO, then drains every FIFO
// in lockstep while strobing the MAC clear/enable, and finally pulses done.
module mac_fifo_loader #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 8,
   parameter int COLS   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] datain,
   output logic [ROWS-1:0]   wrenA,
   output logic              wrenB,
   input  logic [ROWS-1:0]   fullA,
   input  logic              fullB,
   output logic [ROWS-1:0]   rdenA,
   output logic              rdenB,
   input  logic [ROWS-1:0]   emptyA,
   input  logic              emptyB,
   output logic              clr,
   output logic              mac_en,
   output logic              busy,
   output logic              done
);

   // Counter widths; the drain counter must be able to hold COLS itself.
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CNT_W = $clog2(COLS + 1);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(COLS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_LOAD_A = 3'd2,
      S_LOAD_B = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mac_en_q, mac_en_d;

   logic             ready;
   logic             xfer;
   logic             rd_ok;
   logic             rd_go;

   // State, counters and the one-cycle-delayed read strobe that becomes mac_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         cnt_q    <= '0;
         mac_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         mac_en_q <= mac_en_d;
      end
   end

   // Next-state logic and all strobes; writes are combinational from the
   // handshake so a byte is written in the very cycle it is accepted.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      cnt_d    = cnt_q;
      ready    = 1'b0;
      xfer     = 1'b0;
      rd_ok    = ~(|emptyA) & ~emptyB;
      rd_go    = 1'b0;
      datain   = '0;
      wrenA    = '0;
      wrenB    = 1'b0;
      rdenA    = '0;
      rdenB    = 1'b0;
      clr      = 1'b0;
      done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLR;
            end
         end

         S_CLR: begin
            clr     = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD_A;
         end

         S_LOAD_A: begin
            // A full destination FIFO simply withholds ready; nothing is dropped.
            ready  = ~fullA[row_q];
            datain = in_data;
            xfer   = in_valid & ready;
            if (xfer) begin
               wrenA = ROWS'(1) << row_q;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = S_LOAD_B;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end

         S_LOAD_B: begin
            ready  = ~fullB;
            datain = in_data;
            xfer   = in_valid & ready;
            if (xfer) begin
               wrenB = 1'b1;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end

         S_DRAIN: begin
            // Every FIFO is read together or not at all, so rows stay aligned.
            if (rd_ok && (cnt_q < CNT_END)) begin
               rd_go = 1'b1;
               rdenA = '1;
               rdenB = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end else if (cnt_q == CNT_END) begin
               // The final read's mac_en is showing this cycle.
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      mac_en_d = rd_go;
   end

   assign in_ready = ready;
   assign mac_en   = mac_en_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_fifo_loader.sv
// Directed bench for mac_fifo_loader: full load/drain passes with
// backpressure, drain stalls, random valid gaps, stray starts and a
// mid-load reset. FIFOs are modelled as write logs captured on negedge.
module tb_mac_fifo_loader;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_ready, wrenB, fullB, rdenB, emptyB;
   logic       clr, mac_en, busy, done;
   logic [7:0] in_data, datain, wrenA, fullA, rdenA, emptyA;

   always #5 clk = ~clk;

   mac_fifo_loader #(.DATA_W(8), .ROWS(8), .COLS(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .datain(datain), .wrenA(wrenA), .wrenB(wrenB),
      .fullA(fullA), .fullB(fullB),
      .rdenA(rdenA), .rdenB(rdenB),
      .emptyA(emptyA), .emptyB(emptyB),
      .clr(clr), .mac_en(mac_en), .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;

   // FIFO write logs and strobe counters, cumulative over the whole run.
   logic [7:0] mema [8][64];
   int         na [8] = '{default: 0};
   logic [7:0] memb [64];
   int         nb = 0;
   int         rd_cnt = 0, mac_cnt = 0, clr_cnt = 0, done_cnt = 0, desync = 0;

   always @(negedge clk) begin
      if (!rst) begin
         for (int r = 0; r < 8; r++) begin
            if (wrenA[r]) begin
               if (na[r] < 64) mema[r][na[r]] = datain;
               na[r]++;
            end
         end
         if (wrenB) begin
            if (nb < 64) memb[nb] = datain;
            nb++;
         end
         if ((&rdenA) && rdenB) rd_cnt++;
         if ((rdenA != 8'h00 && rdenA != 8'hFF) || ((|rdenA) != rdenB)) desync++;
         if (mac_en) mac_cnt++;
         if (clr) clr_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_wrenA"},    wrenA,    0);
      chk({tag, "_wrenB"},    wrenB,    0);
      chk({tag, "_rdenA"},    rdenA,    0);
      chk({tag, "_rdenB"},    rdenB,    0);
      chk({tag, "_clr"},      clr,      0);
      chk({tag, "_mac_en"},   mac_en,   0);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_done"},     done,     0);
      chk({tag, "_datain"},   datain,   0);
   endtask

   // mode 0: plain, 1: fullA[3] stall, 2: emptyB drain stall,
   // 3: random valid + stray starts, 4: reset at byte 20.
   task automatic run_pass(input int mode);
      int  base_a [8];
      int  base_b, base_rd, base_mac, base_clr, base_done, base_ds;
      int  k, guard, stall_left, mreads, done_at;
      bit  stall_used, pulsed, stalled, xfer, exp_rd, prev_rd, finished;

      for (int r = 0; r < 8; r++) base_a[r] = na[r];
      base_b = nb; base_rd = rd_cnt; base_mac = mac_cnt;
      base_clr = clr_cnt; base_done = done_cnt; base_ds = desync;
      stall_used = 0; pulsed = 0; stall_left = 0;

      start = 1'b1;
      #1;
      chk($sformatf("m%0d_idle_busy", mode), busy, 0);
      cyc();
      start = 1'b0;
      #1;
      chk($sformatf("m%0d_clr_pulse", mode), clr, 1);
      chk($sformatf("m%0d_clr_ready", mode), in_ready, 0);
      chk($sformatf("m%0d_clr_busy", mode), busy, 1);
      cyc();

      k = 0; guard = 0;
      while (k < 72 && guard < 1000) begin
         guard++;
         in_data = 8'(k);
         fullA   = 8'h00;
         start   = 1'b0;
         in_valid = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mode == 1 && k == 24 && !stall_used) begin
            stall_left = 5;
            stall_used = 1;
         end
         if (mode == 3 && k == 66 && !pulsed) begin
            start  = 1'b1;
            pulsed = 1;
         end
         stalled = (stall_left > 0);
         if (stalled) fullA = 8'h08;
         #1;
         if (mode == 4 && k == 20) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            in_valid = 1'b0;
            #1;
            check_idle("abort");
            return;
         end
         xfer = in_valid && !stalled;
         chk($sformatf("m%0d_ready_k%0d", mode, k), in_ready, !stalled);
         chk($sformatf("m%0d_wrA_k%0d", mode, k), wrenA,
             (xfer && k < 64) ? 8'(1 << (k / 8)) : 8'h00);
         chk($sformatf("m%0d_wrB_k%0d", mode, k), wrenB, xfer && k >= 64);
         if (xfer) chk($sformatf("m%0d_din_k%0d", mode, k), datain, k);
         if (stalled) stall_left--;
         cyc();
         if (xfer) k++;
      end
      in_valid = 1'b0;
      fullA = 8'h00;
      start = 1'b0;
      if (k < 72) chk($sformatf("m%0d_load_timeout", mode), k, 72);

      mreads = 0; prev_rd = 0; done_at = -1; finished = 0;
      for (int d = 0; d < 40; d++) begin
         emptyB = (mode == 2 && d >= 2 && d <= 4);
         start  = (mode == 3 && d == 3);
         #1;
         exp_rd = !emptyB && mreads < 8;
         chk($sformatf("m%0d_rdA_d%0d", mode, d), rdenA, exp_rd ? 8'hFF : 8'h00);
         chk($sformatf("m%0d_rdB_d%0d", mode, d), rdenB, exp_rd);
         chk($sformatf("m%0d_mac_d%0d", mode, d), mac_en, prev_rd);
         chk($sformatf("m%0d_done_d%0d", mode, d), done, d == done_at);
         chk($sformatf("m%0d_busy_d%0d", mode, d), busy, 1);
         chk($sformatf("m%0d_ready_d%0d", mode, d), in_ready, 0);
         if (exp_rd) begin
            mreads++;
            if (mreads == 8) done_at = d + 2;
         end
         prev_rd = exp_rd;
         cyc();
         if (d == done_at) begin
            finished = 1;
            break;
         end
      end
      emptyB = 1'b0;
      start  = 1'b0;
      #1;
      if (!finished) chk($sformatf("m%0d_drain_timeout", mode), finished, 1);
      chk($sformatf("m%0d_post_busy", mode), busy, 0);
      chk($sformatf("m%0d_post_done", mode), done, 0);
      chk($sformatf("m%0d_post_clr", mode), clr, 0);
      chk($sformatf("m%0d_reads", mode), rd_cnt - base_rd, 8);
      chk($sformatf("m%0d_macs", mode), mac_cnt - base_mac, 8);
      chk($sformatf("m%0d_clrs", mode), clr_cnt - base_clr, 1);
      chk($sformatf("m%0d_dones", mode), done_cnt - base_done, 1);
      chk($sformatf("m%0d_desync", mode), desync - base_ds, 0);
      for (int r = 0; r < 8; r++) begin
         chk($sformatf("m%0d_cntA%0d", mode, r), na[r] - base_a[r], 8);
         for (int i = 0; i < 8; i++)
            if (base_a[r] + i < 64)
               chk($sformatf("m%0d_A%0d_%0d", mode, r, i), mema[r][base_a[r] + i], 8 * r + i);
      end
      chk($sformatf("m%0d_cntB", mode), nb - base_b, 8);
      for (int i = 0; i < 8; i++)
         if (base_b + i < 64)
            chk($sformatf("m%0d_B_%0d", mode, i), memb[base_b + i], 64 + i);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h5A;
      fullA = 8'h00; fullB = 1'b0; emptyA = 8'h00; emptyB = 1'b0;
      repeat (3) cyc();
      check_idle("rst");
      rst = 1'b0;
      in_valid = 1'b1;
      cyc();
      check_idle("idle");
      in_valid = 1'b0;

      run_pass(0);
      run_pass(1);
      run_pass(2);
      run_pass(3);
      run_pass(4);
      cyc();
      check_idle("after_abort");
      run_pass(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
